// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding and default widths for the multiplier/accumulator slice
package mult_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  localparam int DEF_PROD_W = 4;
  localparam int DEF_ACC_W = 6;
  localparam int DEF_BATCH = 4;
endpackage

// File: rtl/sat_add.sv
// sat_add: W-bit unsigned saturating adder; ports a, b in, sum (clamped to 2^W-1), ovf (saturated) out
module sat_add #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] full;
  assign full = {1'b0, a} + {1'b0, b};
  assign ovf = full[W];
  assign sum = ovf ? '1 : full[W-1:0];
endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums BATCH products with saturation, holds result until out_ready; ports clk, rst_n, clr, in_valid/in_ready/prod in, out_valid/out_ready/acc_out/ovf out
module prod_accum
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int BATCH = DEF_BATCH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);
  localparam int CNT_W = $clog2(BATCH);
  state_t state, state_d;
  logic [ACC_W-1:0] acc, acc_d, add_sum;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic ovf_q, ovf_d, add_ovf, xfer, last, rel, wipe;
  sat_add #(.W(ACC_W)) u_add (
    .a(acc),
    .b(ACC_W'(prod)),
    .sum(add_sum),
    .ovf(add_ovf)
  );
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  assign acc_out = acc;
  assign ovf = ovf_q;
  always_comb begin
    xfer = in_valid && in_ready;
    last = cnt == CNT_W'(BATCH - 1);
    rel = state == HOLD && out_ready;
    wipe = clr || rel;
    state_d = clr ? ACCUM : state == ACCUM ? (xfer && last ? HOLD : ACCUM) : (out_ready ? ACCUM : HOLD);
    acc_d = wipe ? '0 : xfer ? add_sum : acc;
    cnt_d = (wipe || (xfer && last)) ? '0 : xfer ? cnt + CNT_W'(1) : cnt;
    ovf_d = wipe ? 1'b0 : xfer ? (ovf_q || add_ovf) : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_d;
      acc <= acc_d;
      cnt <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter PROD_W, default 4: width of the incoming product from the 2x2 combinational multiplier.
REQ-002 Parameter BATCH, default 4: number of products summed per result; legal range 2..16.
REQ-003 Parameter ACC_W, default 6: accumulator and result width; ACC_W >= PROD_W SHALL hold.
REQ-004 Port clk, input, 1: single clock, rising-edge active.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port clr, input, 1: synchronous batch abort.
REQ-007 Port in_valid, input, 1: prod is valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts prod this cycle.
REQ-009 Port prod, input, PROD_W: unsigned product from the multiplier output s.
REQ-010 Port out_valid, output, 1: acc_out and ovf hold a completed batch.
REQ-011 Port out_ready, input, 1: downstream consumes the result.
REQ-012 Port acc_out, output, ACC_W: saturated batch sum.
REQ-013 Port ovf, output, 1: batch sum exceeded 2^ACC_W-1.

Function
REQ-014 The FSM SHALL have two states, ACCUM and HOLD.
REQ-015 In ACCUM: in_ready=1 and out_valid=0.
REQ-016 In HOLD: in_ready=0 and out_valid=1.
REQ-017 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-018 On each transfer, acc SHALL become sat(acc+prod), computed at ACC_W+1 bits and clamped to 2^ACC_W-1.
REQ-019 On each transfer, cnt SHALL increment by 1.
REQ-020 ovf SHALL set when any addition in the batch saturates, and SHALL stay set until the batch is released.
REQ-021 The transfer with cnt==BATCH-1 SHALL move the FSM to HOLD on the same edge, with acc_out equal to the final sum (latency: 1 cycle after the last accepted product).
REQ-022 acc_out SHALL be the accumulator register; it is visible and changing during ACCUM and stable throughout HOLD.
REQ-023 In HOLD, when out_ready=1 at an edge, the FSM SHALL return to ACCUM and clear acc, cnt and ovf to 0.
REQ-024 In HOLD, while out_ready=0, all outputs SHALL hold; in_valid SHALL be ignored.
REQ-025 A product presented in the same cycle as the HOLD->ACCUM release SHALL NOT be accepted, because in_ready=0 in that cycle.
REQ-026 clr=1 SHALL clear acc, cnt and ovf and force ACCUM at the next edge from any state, discarding any concurrent transfer or out_ready.
REQ-027 cnt SHALL use ceil(log2(BATCH)) bits and SHALL never wrap past BATCH-1.
REQ-028 in_valid=0 for any number of cycles SHALL leave state unchanged (gaps allowed).

Reset
REQ-029 While rst_n=0: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1, acc_out=0, with no clock required.
REQ-030 Reset asserted mid-batch or in HOLD SHALL discard the partial or held result.
REQ-031 Deassertion SHALL be synchronised externally; the first edge after deassertion may accept a transfer.

Structure
REQ-032 Package mult_pkg SHALL hold the state encoding (ACCUM=0, HOLD=1) and the default PROD_W, ACC_W and BATCH constants, shared with the multiplier top.
REQ-033 One sub-module, sat_add (ACC_W-bit unsigned saturating adder with an overflow flag), SHALL implement REQ-018; the FSM, counter and registers stay in prod_accum.
REQ-034 The multiplier s output SHALL connect directly to prod; prod_accum SHALL NOT register prod before the adder.

Verification
REQ-035 Defaults; products 3,6,9,2 with in_valid held high -> out_valid rises 1 cycle after the 4th, acc_out=20, ovf=0.
REQ-036 ACC_W=5; products 9,9,9,9 -> acc_out=31, ovf=1; out_ready pulse -> acc_out=0, ovf=0, in_ready=1 next cycle.
REQ-037 Batch complete, out_ready=0 for 10 cycles while in_valid=1 with prod=5 -> acc_out stays 20, in_ready=0, no product lost after the release.
REQ-038 Two products (4,4) accepted, then clr=1 for 1 cycle, then 1,1,1,1 -> acc_out=4.
REQ-039 rst_n driven low asynchronously between clock edges after 3 products -> all outputs reach reset values immediately; after release, 2,2,2,2 -> acc_out=8.
REQ-040 Alternating in_valid (1,0,1,0,...) with products 1,2,3,4 -> acc_out=10 on the cycle after the 4th accepted product.
